// File: rtl/foo_pkg.sv
//============================================================================
// Module   : foo_pkg
// Brief    : Shared widths and defaults for the foo operand feed and accumulator.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

package foo_pkg;
    localparam int WORD_W        = 64;
    localparam int LONG_W        = 129;
    localparam int DEPTH_DEFAULT = 4;
endpackage

`default_nettype wire

// File: rtl/foo_feed_if.sv
//============================================================================
// Module   : foo_feed_if
// Brief    : Operand-feed handshake, side-band and status bundle.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

interface foo_feed_if #(
    parameter int DEPTH = foo_pkg::DEPTH_DEFAULT,
    parameter int CNT_W = 32
);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic                        in_valid;
    logic                        in_ready;
    logic [foo_pkg::WORD_W-1:0]  in_data;
    logic [foo_pkg::LONG_W-1:0]  in_long;
    logic                        hold;
    logic [foo_pkg::WORD_W-1:0]  a_out;
    logic [foo_pkg::LONG_W-1:0]  long_q;
    logic [LVL_W-1:0]            level;
    logic [CNT_W-1:0]            pop_count;

    modport master (
        output in_valid, in_data, in_long, hold,
        input  in_ready, a_out, long_q, level, pop_count
    );

    modport slave (
        input  in_valid, in_data, in_long, hold,
        output in_ready, a_out, long_q, level, pop_count
    );
endinterface

`default_nettype wire

// File: rtl/foo_feed_fifo.sv
//============================================================================
// Module   : foo_feed_fifo
// Brief    : Operand storage with wrapping pointers and occupancy; unregistered head.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module foo_feed_fifo
    import foo_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEFAULT,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              push,
    input  wire logic [WORD_W-1:0] push_data,
    input  wire logic              pop,
    output logic      [WORD_W-1:0] head_data,
    output logic      [LVL_W-1:0]  level,
    output logic                   full,
    output logic                   empty
);
    localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              do_push, do_pop;

    assign full      = (level_q == LVL_W'(DEPTH));
    assign empty     = (level_q == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem_q[rd_ptr_q];
    assign level     = level_q;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end
endmodule

`default_nettype wire

// File: rtl/foo_feed.sv
//============================================================================
// Module   : foo_feed
// Brief    : FIFO-buffered operand feed into a downstream accumulator addend port.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module foo_feed
    import foo_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int CNT_W = 32
) (
    input  wire logic  clk,
    input  wire logic  rst,
    foo_feed_if.slave  bus
);
    localparam int               LVL_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic              in_ready, push, pop, full, empty;
    logic [WORD_W-1:0] head_data;
    logic [LVL_W-1:0]  level;

    logic [WORD_W-1:0] a_out_q, a_out_d;
    logic [LONG_W-1:0] long_q_q, long_q_d;
    logic [CNT_W-1:0]  pop_count_q, pop_count_d;

    // Ready depends only on stored occupancy, never on this cycle's valid or hold.
    assign in_ready = !full && !rst;
    assign push     = bus.in_valid && in_ready;
    assign pop      = !bus.hold && !empty;

    foo_feed_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (bus.in_data),
        .pop       (pop),
        .head_data (head_data),
        .level     (level),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        a_out_d     = pop ? head_data : '0;
        long_q_d    = push ? bus.in_long : long_q_q;
        pop_count_d = pop ? pop_count_q + CNT_ONE : pop_count_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_out_q     <= '0;
            long_q_q    <= '0;
            pop_count_q <= '0;
        end else begin
            a_out_q     <= a_out_d;
            long_q_q    <= long_q_d;
            pop_count_q <= pop_count_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.a_out     = a_out_q;
    assign bus.long_q    = long_q_q;
    assign bus.level     = level;
    assign bus.pop_count = pop_count_q;
endmodule

`default_nettype wire

// File: doc/foo_feed.md
FOO_FEED -- requirements
Module: foo_feed

Interface
REQ-001 Parameter DEPTH, default 4, number of operand FIFO entries; power of two, 2..16.
REQ-002 Parameter CNT_W, default 32, width of pop_count.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream operand valid.
REQ-006 in_ready  output  1  block can accept an operand this cycle.
REQ-007 in_data  input  64  operand, unsigned.
REQ-008 in_long  input  129  wide side-band word, captured together with each accepted operand.
REQ-009 hold  input  1  stall draining; while high, no pop occurs.
REQ-010 a_out  output  64  registered operand to the downstream accumulator's 64-bit addend input; 0 when nothing was popped.
REQ-011 long_q  output  129  registered side-band word of the most recently accepted operand.
REQ-012 level  output  $clog2(DEPTH+1)  current FIFO occupancy.
REQ-013 pop_count  output  CNT_W  total operands delivered on a_out since reset.

Function
REQ-014 Push occurs when in_valid && in_ready at the clock edge; in_data is written at the tail.
REQ-015 in_ready SHALL be (level < DEPTH) && !rst, from registered state only; no combinational path from in_valid or hold.
REQ-016 Pop occurs at a clock edge when !hold && level > 0; the head entry is registered into a_out at that edge.
REQ-017 At an edge without a pop, a_out SHALL load 64'd0, so downstream adds only its own +1 that cycle.
REQ-018 Latency: an operand pushed into an empty FIFO at edge N SHALL appear on a_out after edge N+1 (earliest), for exactly one cycle.
REQ-019 Order SHALL be strictly FIFO; no operand is dropped or duplicated.
REQ-020 Simultaneous push and pop: both take effect; level unchanged.
REQ-021 Full (level == DEPTH): in_ready low; a pop that edge frees a slot, and in_ready rises the following cycle.
REQ-022 Empty: no pop regardless of hold; a_out loads 0.
REQ-023 Read/write pointers wrap modulo DEPTH; level never exceeds DEPTH or underflows.
REQ-024 long_q SHALL load in_long on every push and hold otherwise; it is independent of hold.
REQ-025 pop_count SHALL increment by 1 on every pop and wrap from 2^CNT_W-1 to 0.
REQ-026 hold asserted mid-stream freezes FIFO contents and pointers; draining resumes in order at the first edge with hold low.

Reset
REQ-027 While rst is high: a_out = 0, long_q = 0, level = 0, pop_count = 0, pointers = 0, in_ready = 0.
REQ-028 Reset mid-operation SHALL discard all stored operands immediately; FIFO storage contents need not be cleared.
REQ-029 First push is possible at the first rising edge after rst deasserts.

Structure
REQ-030 Shared package foo_pkg holds WORD_W = 64, LONG_W = 129 and DEPTH_DEFAULT = 4; foo_feed and the accumulator use them.
REQ-031 Storage and pointers are one sub-module, foo_feed_fifo (push/pop/level, no output register); foo_feed adds the a_out/long_q registers and pop_count.

Verification
REQ-032 Reset, then push 5, 7, 9 on consecutive edges with hold=0 -> a_out sequence 0, 5, 7, 9, 0; pop_count = 3.
REQ-033 hold=1, push 1, 2, 3, 4, 5 every cycle -> level reaches 4, in_ready low, 5 not accepted until hold drops; then a_out = 1, 2, 3, 4, 5 in order.
REQ-034 Steady push/pop every cycle at level 2 -> level stays 2; no operand lost over 100 operands (scoreboard).
REQ-035 Push with in_long = 129'h1_0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF -> long_q equals it the next cycle; unchanged while idle.
REQ-036 Force pop_count to 2^32-1 via 2^32-1 pops (or a CNT_W=4 build with 15 pops), one more pop -> pop_count = 0.
REQ-037 Assert rst asynchronously with level = 3 -> level, a_out, pop_count read 0 before the next edge; after release, the first push yields that value, not stale data.
